audio_adc_rx: RTL

- Codec-side receive path for the audio subsystem: mirror of the DAC transmit path.
- Deserialises I2S ADC data (ADCDAT, clocked by codec BCLK and framed by ADCLRCK) into left/right sample pairs.
- Buffers pairs in an on-chip FIFO; exposes them to the Nios/Avalon bus through a 4-word slave with an interrupt for the piano's record/monitor features.

---
 rtl/audio_adc_rx.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/audio_adc_rx.sv
// I2S ADC receive path: deserialises ADCDAT into left/right pairs, buffers them in a FIFO
// and exposes them on a 4-word Avalon slave. Define AUDIO_ADC_RX_OVF_IRQ_EN to add CTRL.OE.
module audio_adc_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic        sys_clk_clk,
    input  logic        sys_reset_reset_n,
    input  logic        audio_BCLK,
    input  logic        audio_ADCLRCK,
    input  logic        audio_ADCDAT,
    input  logic [1:0]  audio_slave_address,
    input  logic        audio_slave_chipselect,
    input  logic        audio_slave_read,
    input  logic        audio_slave_write,
    input  logic [31:0] audio_slave_writedata,
    output logic [31:0] audio_slave_readdata,
    output logic        audio_irq_irq
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(DATA_WIDTH + 1);
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] HALF_C  = (FIFO_AW+1)'(DEPTH / 2);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_SHIFT, S_WAIT} state_t;

    // ---------------- synchronisers and bit-event detection ----------------
    logic [1:0] bclk_sq, lrck_sq, dat_sq;
    logic       bclk_prev_q, lrck_last_q;
    logic       lrck_s, dat_s, bit_ev, lrck_edge;

    assign lrck_s    = lrck_sq[1];
    assign dat_s     = dat_sq[1];
    assign bit_ev    = bclk_sq[1] & ~bclk_prev_q;
    assign lrck_edge = bit_ev & (lrck_s != lrck_last_q);

    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n) begin
            bclk_sq     <= '0;
            lrck_sq     <= '0;
            dat_sq      <= '0;
            bclk_prev_q <= 1'b0;
            lrck_last_q <= 1'b0;
        end else begin
            bclk_sq     <= {bclk_sq[0], audio_BCLK};
            lrck_sq     <= {lrck_sq[0], audio_ADCLRCK};
            dat_sq      <= {dat_sq[0], audio_ADCDAT};
            bclk_prev_q <= bclk_sq[1];
            if (bit_ev) lrck_last_q <= lrck_s;
        end
    end

    // ---------------- control register decode ----------------
    logic wr_ctrl, rd_en, clear, pop;
    logic re_q, re_d, enable_q, enable_d, ovf_q, ovf_d, oe;
    logic [FIFO_AW:0] cnt_q, cnt_d;
    logic full, empty, ri;

    assign wr_ctrl  = audio_slave_chipselect & audio_slave_write & (audio_slave_address == 2'd0);
    assign rd_en    = audio_slave_chipselect & audio_slave_read;
    assign clear    = wr_ctrl & audio_slave_writedata[1];
    assign re_d     = wr_ctrl ? audio_slave_writedata[0] : re_q;
    assign enable_d = wr_ctrl ? audio_slave_writedata[2] : enable_q;
    assign full     = (cnt_q == DEPTH_C);
    assign empty    = (cnt_q == '0);
    assign ri       = (cnt_q >= HALF_C);
    assign pop      = rd_en & (audio_slave_address == 2'd3) & ~empty;

    // ---------------- frame FSM ----------------
    state_t                state_q, state_d;
    logic [CW-1:0]         bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d, word;
    logic                  word_done;

    assign word = {sh_q[DATA_WIDTH-2:0], dat_s};

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        sh_d      = sh_q;
        word_done = 1'b0;
        if (bit_ev) begin
            unique case (state_q)
                S_IDLE:  if (enable_q && lrck_edge) state_d = S_DELAY;
                S_DELAY: begin
                    state_d = S_SHIFT;
                    bcnt_d  = '0;
                end
                S_SHIFT: begin
                    if (lrck_edge) begin
                        state_d = S_DELAY;
                    end else begin
                        sh_d = word;
                        if (bcnt_q == CW'(DATA_WIDTH - 1)) begin
                            word_done = 1'b1;
                            state_d   = S_WAIT;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
                S_WAIT:  if (lrck_edge) state_d = S_DELAY;
                default: state_d = S_IDLE;
            endcase
        end
        // Disabling drops any frame in progress on the very next edge.
        if (!enable_d) state_d = S_IDLE;
    end

    // ---------------- holding registers and push ----------------
    logic [DATA_WIDTH-1:0] left_q, right_q;
    logic                  left_vld_q, left_vld_d;
    logic                  push_req, push_ok, ovf_set;

    assign push_req = word_done & lrck_s & left_vld_q & enable_d;
    assign push_ok  = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;

    always_comb begin
        left_vld_d = left_vld_q;
        if (push_req)               left_vld_d = 1'b0;
        if (word_done && !lrck_s)   left_vld_d = 1'b1;
        if (clear || !enable_d)     left_vld_d = 1'b0;
    end

    always_comb begin
        ovf_d = ovf_q;
        if (wr_ctrl && audio_slave_writedata[9]) ovf_d = 1'b0;
        if (ovf_set)                             ovf_d = 1'b1;
        if (clear)                               ovf_d = 1'b0;
    end

    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n) begin
            state_q    <= S_IDLE;
            bcnt_q     <= '0;
            sh_q       <= '0;
            left_q     <= '0;
            right_q    <= '0;
            left_vld_q <= 1'b0;
            re_q       <= 1'b0;
            enable_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            sh_q       <= sh_d;
            left_vld_q <= left_vld_d;
            re_q       <= re_d;
            enable_q   <= enable_d;
            ovf_q      <= ovf_d;
            if (word_done) begin
                if (lrck_s) right_q <= word;
                else        left_q  <= word;
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [FIFO_AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [2*DATA_WIDTH-1:0] head;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge sys_clk_clk) begin
        if (push_ok && !clear) mem_q[wr_ptr_q] <= {left_q, word};
    end

    // ---------------- optional overflow interrupt enable ----------------
`ifdef AUDIO_ADC_RX_OVF_IRQ_EN
    logic oe_q;
    assign oe = oe_q;
    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n)  oe_q <= 1'b0;
        else if (wr_ctrl)        oe_q <= audio_slave_writedata[3];
    end
    logic unused_bits;
    assign unused_bits = ^{audio_slave_writedata[31:10], audio_slave_writedata[8:4],
                           sh_q[DATA_WIDTH-1], right_q};
`else
    assign oe = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{audio_slave_writedata[31:10], audio_slave_writedata[8:3],
                           sh_q[DATA_WIDTH-1], right_q};
`endif

    // ---------------- read port and interrupt ----------------
    function automatic logic [31:0] sext(input logic [DATA_WIDTH-1:0] x);
        return {{(32-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    endfunction

    logic [31:0] readdata_q, readdata_d;
    logic        irq_q;

    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) begin
            unique case (audio_slave_address)
                2'd0: readdata_d = {22'd0, ovf_q, ri, 4'd0, oe, enable_q, 1'b0, re_q};
                2'd1: readdata_d = {16'd0, 8'(cnt_q), 8'(DEPTH_C - cnt_q)};
                2'd2: readdata_d = empty ? 32'd0 : sext(head[2*DATA_WIDTH-1:DATA_WIDTH]);
                default: readdata_d = empty ? 32'd0 : sext(head[DATA_WIDTH-1:0]);
            endcase
        end
    end

    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n) begin
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            readdata_q <= readdata_d;
            irq_q      <= (re_q & ri) | (oe & ovf_q);
        end
    end

    assign audio_slave_readdata = readdata_q;
    assign audio_irq_irq        = irq_q;

endmodule
